pc_stack_unit: RTL and testbench



---
 rtl/pc_stack_unit.sv | 117 +++++++++++
 tb/tb_pc_stack_unit.sv | 113 +++++++++++
 2 files changed

// File: rtl/pc_stack_unit.sv
// rtl/pc_stack_unit.sv - 16-bit program counter with hardware return-address stack.
// Optional macro PCSTACK_ERR_CLR_EN adds err_clr to clear the sticky error flags.
module pc_stack_unit #(
    parameter int          DEPTH    = 8,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       halt,
    input  logic                       inc,
    input  logic                       load,
    input  logic                       call,
    input  logic                       ret,
    input  logic [15:0]                target,
`ifdef PCSTACK_ERR_CLR_EN
    input  logic                       err_clr,
`endif
    output logic [15:0]                pc,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow_err,
    output logic                       underflow_err
);
    localparam int DW = $clog2(DEPTH + 1);
    localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);
    localparam logic [DW-1:0] ONE       = DW'(1);

    logic [15:0]   pc_q, pc_d;
    logic [DW-1:0] depth_q, depth_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic [15:0]   stack_q [DEPTH];
    logic [15:0]   stack_d [DEPTH];
    logic [15:0]   top;

    always_comb begin
        pc_d    = pc_q;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        stack_d = stack_q;
        top     = '0;

        // Decoded read of the top-of-stack entry; avoids a truncated index.
        for (int i = 0; i < DEPTH; i++) begin
            if (DW'(i) == depth_q - ONE) begin
                top = stack_q[i];
            end
        end

        if (reset) begin
            pc_d    = RESET_PC;
            depth_d = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else if (!halt) begin
`ifdef PCSTACK_ERR_CLR_EN
            // Applied first so an error raised below in the same cycle wins.
            if (err_clr) begin
                ovf_d = 1'b0;
                unf_d = 1'b0;
            end
`endif
            if (ret) begin
                if (!empty_q) begin
                    pc_d    = top;
                    depth_d = depth_q - ONE;
                end else begin
                    unf_d = 1'b1;
                end
            end else if (call) begin
                if (!full_q) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (DW'(i) == depth_q) begin
                            stack_d[i] = pc_q + 16'd1;
                        end
                    end
                    pc_d    = target;
                    depth_d = depth_q + ONE;
                end else begin
                    ovf_d = 1'b1;
                end
            end else if (load) begin
                pc_d = target;
            end else if (inc) begin
                pc_d = pc_q + 16'd1;
            end
        end

        full_d  = (depth_d == DEPTH_MAX);
        empty_d = (depth_d == '0);
    end

    always_ff @(posedge clk) begin
        pc_q    <= pc_d;
        depth_q <= depth_d;
        full_q  <= full_d;
        empty_q <= empty_d;
        ovf_q   <= ovf_d;
        unf_q   <= unf_d;
    end

    // Stack RAM needs no reset: depth alone defines which entries are valid.
    always_ff @(posedge clk) begin
        stack_q <= stack_d;
    end

    assign pc            = pc_q;
    assign depth         = depth_q;
    assign full          = full_q;
    assign empty         = empty_q;
    assign overflow_err  = ovf_q;
    assign underflow_err = unf_q;
endmodule

// File: tb/tb_pc_stack_unit.sv
// tb/tb_pc_stack_unit.sv - directed table-driven bench for pc_stack_unit.
module tb_pc_stack_unit;
    logic        clk = 1'b0;
    logic        reset, halt, inc, load, call, ret;
    logic [15:0] target;
    logic [15:0] pc;
    logic [3:0]  depth;
    logic        full, empty, overflow_err, underflow_err;

    int pass_cnt = 0;
    int total    = 0;

    pc_stack_unit #(.DEPTH(8), .RESET_PC(16'h0000)) dut (
        .clk(clk), .reset(reset), .halt(halt), .inc(inc), .load(load),
        .call(call), .ret(ret), .target(target),
`ifdef PCSTACK_ERR_CLR_EN
        .err_clr(1'b0),
`endif
        .pc(pc), .depth(depth), .full(full), .empty(empty),
        .overflow_err(overflow_err), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, hlt, inc, ld, cl, rt;
        logic [15:0] tgt;
        logic [15:0] pc;
        logic [3:0]  dep;
        logic        ovf, unf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, h, i, l, c, t, input logic [15:0] tg,
                                input logic [15:0] p, input logic [3:0] d,
                                input logic o, u);
        vec_t v;
        v.rst = r; v.hlt = h; v.inc = i; v.ld = l; v.cl = c; v.rt = t;
        v.tgt = tg; v.pc = p; v.dep = d; v.ovf = o; v.unf = u;
        return v;
    endfunction

    task automatic chk(input string name, input int step, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s step %0d: got %h expected %h", name, step, got, exp);
    endtask

    task automatic apply(input vec_t v, input int step);
        reset = v.rst; halt = v.hlt; inc = v.inc; load = v.ld; call = v.cl; ret = v.rt;
        target = v.tgt;
        @(posedge clk);
        #1;
        chk("pc", step, pc, v.pc);
        chk("depth", step, {12'h0, depth}, {12'h0, v.dep});
        chk("full", step, {15'h0, full}, {15'h0, v.dep == 4'd8});
        chk("empty", step, {15'h0, empty}, {15'h0, v.dep == 4'd0});
        chk("overflow_err", step, {15'h0, overflow_err}, {15'h0, v.ovf});
        chk("underflow_err", step, {15'h0, underflow_err}, {15'h0, v.unf});
    endtask

    initial begin
        reset = 0; halt = 0; inc = 0; load = 0; call = 0; ret = 0; target = '0;
        //                rst h i l c r  target    pc       dep  o  u
        tbl.push_back(mk(1, 0,0,0,0,0, 16'h0000, 16'h0000, 4'd0, 0, 0));
        tbl.push_back(mk(0, 0,1,0,0,0, 16'h0000, 16'h0001, 4'd0, 0, 0));
        tbl.push_back(mk(0, 0,1,0,0,0, 16'h0000, 16'h0002, 4'd0, 0, 0));
        tbl.push_back(mk(0, 0,1,0,0,0, 16'h0000, 16'h0003, 4'd0, 0, 0));
        tbl.push_back(mk(0, 0,0,0,0,0, 16'h1234, 16'h0003, 4'd0, 0, 0));
        tbl.push_back(mk(0, 0,0,1,0,0, 16'hFFFE, 16'hFFFE, 4'd0, 0, 0));
        tbl.push_back(mk(0, 0,1,0,0,0, 16'h0000, 16'hFFFF, 4'd0, 0, 0));
        tbl.push_back(mk(0, 0,1,0,0,0, 16'h0000, 16'h0000, 4'd0, 0, 0));
        tbl.push_back(mk(0, 0,0,1,0,0, 16'h0010, 16'h0010, 4'd0, 0, 0));
        tbl.push_back(mk(0, 0,0,0,1,0, 16'h0100, 16'h0100, 4'd1, 0, 0));
        tbl.push_back(mk(0, 0,0,0,1,0, 16'h0200, 16'h0200, 4'd2, 0, 0));
        tbl.push_back(mk(0, 0,0,0,0,1, 16'h0000, 16'h0101, 4'd1, 0, 0));
        tbl.push_back(mk(0, 0,0,0,0,1, 16'h0000, 16'h0011, 4'd0, 0, 0));
        tbl.push_back(mk(0, 0,0,0,0,1, 16'h0000, 16'h0011, 4'd0, 0, 1));
        tbl.push_back(mk(0, 1,1,0,0,0, 16'h0000, 16'h0011, 4'd0, 0, 1));
        tbl.push_back(mk(0, 1,0,0,1,0, 16'h0777, 16'h0011, 4'd0, 0, 1));
        // priority: call beats load/inc, load beats inc, ret beats call
        tbl.push_back(mk(0, 0,1,1,1,0, 16'h0050, 16'h0050, 4'd1, 0, 1));
        tbl.push_back(mk(0, 0,1,1,0,0, 16'h0070, 16'h0070, 4'd1, 0, 1));
        tbl.push_back(mk(0, 0,0,0,1,1, 16'h9999, 16'h0012, 4'd0, 0, 1));
        tbl.push_back(mk(1, 0,1,0,0,0, 16'h0000, 16'h0000, 4'd0, 0, 0));

        for (int k = 0; k < tbl.size(); k++) apply(tbl[k], k);

        // Fill the stack: first return address is 0x0001, then 0x1000+k.
        for (int k = 0; k < 8; k++)
            apply(mk(0,0,0,0,1,0, 16'h1000 + 16'(k), 16'h1000 + 16'(k), 4'(k + 1), 0, 0), 100 + k);
        apply(mk(0,0,0,0,1,0, 16'h2000, 16'h1007, 4'd8, 1, 0), 108);
        // Back-to-back returns unwind in LIFO order.
        for (int k = 7; k >= 1; k--)
            apply(mk(0,0,0,0,0,1, 16'h0000, 16'h1000 + 16'(k), 4'(k), 1, 0), 200 + k);
        apply(mk(0,0,0,0,0,1, 16'h0000, 16'h0001, 4'd0, 1, 0), 200);
        apply(mk(0,0,0,0,0,1, 16'h0000, 16'h0001, 4'd0, 1, 1), 300);
        // Call at 0xFFFF pushes a wrapped return address.
        apply(mk(0,0,0,1,0,0, 16'hFFFF, 16'hFFFF, 4'd0, 1, 1), 301);
        apply(mk(0,0,0,0,1,0, 16'h0300, 16'h0300, 4'd1, 1, 1), 302);
        apply(mk(0,0,0,0,0,1, 16'h0000, 16'h0000, 4'd0, 1, 1), 303);
        // Reset with depth=3 and call asserted the same cycle.
        apply(mk(0,0,0,0,1,0, 16'h0400, 16'h0400, 4'd1, 1, 1), 304);
        apply(mk(0,0,0,0,1,0, 16'h0500, 16'h0500, 4'd2, 1, 1), 305);
        apply(mk(0,0,0,0,1,0, 16'h0600, 16'h0600, 4'd3, 1, 1), 306);
        apply(mk(1,0,0,0,1,0, 16'h0700, 16'h0000, 4'd0, 0, 0), 307);
        apply(mk(0,0,0,0,0,1, 16'h0000, 16'h0000, 4'd0, 0, 1), 308);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
